// File: rtl/axi_write_master.sv
// Burst-stream to AXI4 write converter: one AW beat, len+1 W beats, then waits for B.
// Only one transaction is ever outstanding.
module axi_write_master #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AXI_ID_W = 1,
    parameter logic [AXI_ID_W-1:0] AXI_ID = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_W-1:0]     s_addr,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic [7:0]            s_len,
    output logic                  busy,
    output logic                  error,
    input  logic                  err_clr,
    output logic [AXI_ID_W-1:0]   m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SIZE   = $clog2(STRB_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        len_r;
    logic [7:0]        beat_cnt;
    logic              error_r;
    logic              last_beat;
    logic              beat_fire;
    logic              slverr_fire;
    logic              unused_bresp;

    // Only the SLVERR/DECERR bit of the response matters here.
    assign unused_bresp = m_axi_bresp[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        s_ready       = 1'b0;
        last_beat     = (beat_cnt == len_r);
        beat_fire     = 1'b0;
        slverr_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                m_axi_wvalid = s_valid;
                m_axi_wlast  = last_beat;
                s_ready      = m_axi_wready;
                beat_fire    = s_valid && m_axi_wready;
                if (beat_fire && last_beat) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    slverr_fire = m_axi_bresp[1];
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst context is latched once in IDLE and held until the next burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r   <= '0;
            len_r    <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE && s_valid) begin
            addr_r   <= s_addr;
            len_r    <= s_len;
            beat_cnt <= '0;
        end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Sticky error; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_r <= 1'b0;
        end else if (slverr_fire) begin
            error_r <= 1'b1;
        end else if (err_clr) begin
            error_r <= 1'b0;
        end
    end

    assign busy          = (state != IDLE);
    assign error         = error_r;
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awlen   = len_r;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = s_wdata;
    assign m_axi_wstrb   = s_wstrb;

endmodule
